// File: rtl/sdm_pkg.sv
// Shared types and fixed-point helpers for the multi-channel sigma-delta modulator.
package sdm_pkg;

  typedef enum logic [1:0] {
    ORDER_1 = 2'd1,
    ORDER_2 = 2'd2
  } order_e;

  function automatic longint fx_one(input int bit_width, input int int_width);
    return 64'sd1 <<< (bit_width - int_width - 1);
  endfunction

  function automatic longint fx_neg_one(input int bit_width, input int int_width);
    return -fx_one(bit_width, int_width);
  endfunction

  function automatic longint sat_acc(input longint value, input int acc_width);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sdm_channel.sv
// One modulator channel: loop state, 1-bit decision, saturation and sticky overflow.
module sdm_channel
  import sdm_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int ORDER     = 1,
  parameter int ACC_WIDTH = BIT_WIDTH + 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        step,
  input  logic                        clr,
  input  logic signed [BIT_WIDTH-1:0] x_hold,
  output logic                        y_d,
  output logic                        ovf
);

  localparam logic signed [ACC_WIDTH-1:0] Q_POS = ACC_WIDTH'(fx_one(BIT_WIDTH, INT_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] Q_NEG = ACC_WIDTH'(fx_neg_one(BIT_WIDTH, INT_WIDTH));

  logic signed [ACC_WIDTH-1:0] xe_s;
  logic                        clip_s;
  logic                        ovf_r;

  assign xe_s = ACC_WIDTH'(x_hold);
  assign ovf  = ovf_r;

  if (ORDER == int'(ORDER_1)) begin : g_order1
    logic signed [ACC_WIDTH-1:0] err_r;
    logic signed [ACC_WIDTH-1:0] q_s;
    logic signed [ACC_WIDTH-1:0] err_n_s;
    logic signed [ACC_WIDTH:0]   sum_s;

    // Decision, feedback value and saturated next error
    always_comb begin
      y_d     = (xe_s >= err_r);
      q_s     = y_d ? Q_POS : Q_NEG;
      sum_s   = (ACC_WIDTH+1)'(q_s) - (ACC_WIDTH+1)'(xe_s) + (ACC_WIDTH+1)'(err_r);
      err_n_s = ACC_WIDTH'(sat_acc(longint'(sum_s), ACC_WIDTH));
      clip_s  = (longint'(err_n_s) != longint'(sum_s));
    end

    // Error register
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        err_r <= '0;
      end else if (clr) begin
        err_r <= '0;
      end else if (step) begin
        err_r <= err_n_s;
      end else begin
        err_r <= err_r;
      end
    end
  end else if (ORDER == int'(ORDER_2)) begin : g_order2
    logic signed [ACC_WIDTH-1:0] i1_r;
    logic signed [ACC_WIDTH-1:0] i2_r;
    logic signed [ACC_WIDTH-1:0] q_s;
    logic signed [ACC_WIDTH-1:0] i1n_s;
    logic signed [ACC_WIDTH-1:0] i2n_s;
    logic signed [ACC_WIDTH:0]   s1_s;
    logic signed [ACC_WIDTH:0]   s2_s;

    // Second integrator feeds on the already-saturated first integrator output
    always_comb begin
      y_d    = !i2_r[ACC_WIDTH-1];
      q_s    = y_d ? Q_POS : Q_NEG;
      s1_s   = (ACC_WIDTH+1)'(i1_r) + (ACC_WIDTH+1)'(xe_s) - (ACC_WIDTH+1)'(q_s);
      i1n_s  = ACC_WIDTH'(sat_acc(longint'(s1_s), ACC_WIDTH));
      s2_s   = (ACC_WIDTH+1)'(i2_r) + (ACC_WIDTH+1)'(i1n_s) - (ACC_WIDTH+1)'(q_s);
      i2n_s  = ACC_WIDTH'(sat_acc(longint'(s2_s), ACC_WIDTH));
      clip_s = (longint'(i1n_s) != longint'(s1_s)) || (longint'(i2n_s) != longint'(s2_s));
    end

    // Integrator registers
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        i1_r <= '0;
        i2_r <= '0;
      end else if (clr) begin
        i1_r <= '0;
        i2_r <= '0;
      end else if (step) begin
        i1_r <= i1n_s;
        i2_r <= i2n_s;
      end else begin
        i1_r <= i1_r;
        i2_r <= i2_r;
      end
    end
  end else begin : g_bad_order
    $error("sdm_channel: ORDER must be 1 or 2");
  end

  // Sticky overflow flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_r <= 1'b0;
    end else if (clr) begin
      ovf_r <= 1'b0;
    end else if (step && clip_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

endmodule

// File: rtl/sdm_array.sv
// NUM_CH independent sigma-delta modulators sharing a sample-hold and valid handshake.
module sdm_array
  import sdm_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 1,
  parameter int ORDER     = 1,
  parameter int ACC_WIDTH = BIT_WIDTH + 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        en,
  input  logic                        clr,
  input  logic                        x_valid,
  output logic                        x_ready,
  input  logic [NUM_CH*BIT_WIDTH-1:0] x,
  output logic [NUM_CH-1:0]           y,
  output logic                        y_valid,
  output logic [NUM_CH-1:0]           ovf
);

  logic [NUM_CH*BIT_WIDTH-1:0] x_hold_r;
  logic                        hold_valid_r;
  logic [NUM_CH-1:0]           y_r;
  logic                        y_valid_r;
  logic [NUM_CH-1:0]           y_d_s;
  logic                        step_s;
  logic                        accept_s;

  assign x_ready  = !clr;
  assign accept_s = x_valid && !clr;
  assign step_s   = en && hold_valid_r && !clr;
  assign y        = y_r;
  assign y_valid  = y_valid_r;

  // Zero-order sample hold
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x_hold_r     <= '0;
      hold_valid_r <= 1'b0;
    end else if (clr) begin
      x_hold_r     <= '0;
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      x_hold_r     <= x;
      hold_valid_r <= 1'b1;
    end else begin
      x_hold_r     <= x_hold_r;
      hold_valid_r <= hold_valid_r;
    end
  end

  // Bitstream output register; y keeps its last bit when no step happens
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      y_r       <= '0;
      y_valid_r <= 1'b0;
    end else if (clr) begin
      y_r       <= '0;
      y_valid_r <= 1'b0;
    end else if (step_s) begin
      y_r       <= y_d_s;
      y_valid_r <= 1'b1;
    end else begin
      y_r       <= y_r;
      y_valid_r <= 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sdm_channel #(
      .BIT_WIDTH (BIT_WIDTH),
      .INT_WIDTH (INT_WIDTH),
      .ORDER     (ORDER),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_ch (
      .CLK    (CLK),
      .nRST   (nRST),
      .step   (step_s),
      .clr    (clr),
      .x_hold (x_hold_r[c*BIT_WIDTH +: BIT_WIDTH]),
      .y_d    (y_d_s[c]),
      .ovf    (ovf[c])
    );
  end

endmodule

// File: doc/sdm_array.md
Name: sdm_array

Overview:
- Parametrised multi-channel sigma-delta modulator: the next generation of the team's single-channel first-order SDM unit.
- Converts NUM_CH signed fixed-point samples into NUM_CH 1-bit bitstreams.
- Adds a selectable first/second-order loop, a sample-hold with valid handshake, enable/clear control, saturating accumulators and sticky overflow flags.
- Sits between fixed-point datapath blocks and bitstream (stochastic) operators.

Parameters:
- NUM_CH, 4, number of independent modulator channels.
- BIT_WIDTH, 16, signed input sample width.
- INT_WIDTH, 1, integer bits. Fraction bits FRAC = BIT_WIDTH-INT_WIDTH-1. +1.0 = 1<<FRAC.
- ORDER, 1, loop order. Legal values are 1 or 2; any other value is an elaboration error.
- ACC_WIDTH, BIT_WIDTH+2, signed width of internal error/integrator registers.

Ports:
- CLK, input, 1, clock.
- nRST, input, 1, asynchronous active-low reset.
- en, input, 1, modulator step enable.
- clr, input, 1, synchronous clear of all loop state, hold registers and flags.
- x_valid, input, 1, input sample vector is valid.
- x_ready, output, 1, block accepts x this cycle; equals !clr.
- x, input, NUM_CH*BIT_WIDTH, packed signed samples; channel c occupies bits [c*BIT_WIDTH +: BIT_WIDTH].
- y, output, NUM_CH, registered bitstream bit per channel.
- y_valid, output, 1, y was produced by a step on the previous edge.
- ovf, output, NUM_CH, sticky per-channel saturation flag.

Behaviour:
- Reset (nRST=0, async): x_hold, all state, y, y_valid, ovf and hold_valid all go to 0. x_ready follows clr combinationally.
- Accept: when x_valid && x_ready, x_hold[c] <= x[c] and hold_valid <= 1. Otherwise x_hold keeps its value (zero-order hold).
- Step condition: step = en && hold_valid && !clr.
- Clear: when clr=1, all state, x_hold, hold_valid, y, y_valid and ovf go to 0 on the next edge. clr overrides a simultaneous x_valid and en.
- Quantiser value q = +1.0 if the bit being emitted is 1, else -1.0. q is sign-extended to ACC_WIDTH.
- All sums are computed at ACC_WIDTH+1 bits and then saturated to the signed ACC_WIDTH range. Any clipping sets ovf[c] on that step.
- ORDER=1, state err:
  - y_d = (x_hold >= err), signed compare.
  - err <= sat(q - x_hold + err).
- ORDER=2, states i1, i2:
  - y_d = (i2 >= 0).
  - i1n = sat(i1 + x_hold - q).
  - i1 <= i1n.
  - i2 <= sat(i2 + i1n - q).
- On a step: y[c] <= y_d and y_valid <= 1.
- Without a step: state holds, y holds its last value, y_valid <= 0.
- Latency: a sample accepted at edge k is first used by a step at edge k+1. Its y is visible after edge k+1, so it is 2 cycles from x_valid to y_valid.
- Channels are fully independent. A simultaneous accept and step uses the old x_hold for the step.
- nRST asserted mid-stream returns everything to reset values immediately. The first step after release behaves exactly as after power-up.
- Inputs beyond ±1.0 are legal. They drive saturation and set ovf; the design has no undefined behaviour.

Decomposition:
- Package sdm_pkg:
  - localparam functions fx_one(BIT_WIDTH, INT_WIDTH) and fx_neg_one(...).
  - Function sat_acc(value, ACC_WIDTH).
  - typedef for order_e (ORDER_1, ORDER_2).
- Sub-module sdm_channel (BIT_WIDTH, INT_WIDTH, ORDER, ACC_WIDTH):
  - Contains one channel's loop state, decision, saturation and ovf.
  - Ports: step, clr, x_hold, y_d, ovf.
- sdm_array instantiates NUM_CH copies via generate. It owns the hold registers, handshake, y/y_valid registers and hold_valid.

Test Plan:
- Zero input, ORDER=1, BIT_WIDTH=16, INT_WIDTH=1: x=0 all channels, en=1, x_valid pulsed once -> y_valid rises 2 cycles later; y = 1,0,1,0,... on every channel; ovf=0.
- Density, ORDER=1: ch0 x=0x2000 (+0.5), ch1 x=0xE000 (-0.5) -> over 16 consecutive steps ch0 emits exactly 12 ones and ch1 exactly 4; ch2/ch3 (x=0) emit 8.
- ORDER=2, x=0x1000 (+0.25) -> ones count over 64 steps is 40 ±1; i1 and i2 stay within ±3.0; ovf=0.
- Saturation, ORDER=2: x=0x7FFF -> ovf[c] goes high within 8 steps and stays high with en toggling; clr=1 for one cycle -> ovf=0, y=0, y_valid=0, and no step until a new x_valid.
- Enable/hold: drop en for 5 cycles mid-stream -> y frozen, y_valid=0. On re-enable the sequence continues exactly where it paused (compare against an uninterrupted golden run). An x_valid with new data during the pause is used by the first resumed step.
- Async reset: assert nRST for half a cycle mid-stream -> all outputs 0 immediately. After release, with no new x_valid, no step occurs (hold_valid=0). A new x=0 stream reproduces the power-up 1,0,1,0 sequence.
